dkjr_obj_linebuf_ctrl: RTL and testbench
========================================

# dkjr_obj_linebuf_ctrl

Controller for the 256×6 single-port object line-buffer RAM: it is the initiator that drives the RAM's ce/oce/wre/ad/din port and consumes its dout. It sits between the sprite draw engine and the video mixer, and arbitrates one RAM port between two jobs. Display reads take priority and optionally clear each location after reading it. Sprite pixel writes are priority-checked, so an existing opaque pixel is never overwritten.

## Interface
Parameters:
- AW, 8, line-buffer address width (256 locations)
- DW, 6, pixel width: [5:2] palette, [1:0] pixel code; code 2'b00 = transparent

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_strobe  in  1  one-cycle display request for location pix_x
- pix_x  in  AW  display read address
- pix_color  out  DW  pixel read for display, registered
- pix_valid  out  1  one-cycle pulse; pix_color updated
- pix_overrun  out  1  sticky: a display request was lost
- draw_valid  in  1  sprite engine offers a pixel
- draw_ready  out  1  pixel accepted when draw_valid && draw_ready
- draw_x  in  AW  sprite pixel address
- draw_color  in  DW  sprite pixel value
- ram_ce  out  1  RAM clock enable
- ram_oce  out  1  RAM output enable, constant 1
- ram_reset  out  1  equals reset
- ram_wre  out  1  RAM write enable
- ram_ad  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; valid the cycle after the read edge (bypass mode, 1-cycle latency)

## Operation
- FSM states: IDLE, DISP_RD, DRAW_RD.
- IDLE, display pending (pix_strobe or pend flag):
  - Drive ram_ce=1, ram_wre=0, ram_ad=pending address.
  - Clear pend. Go to DISP_RD.
- IDLE, no display pending, draw_valid:
  - Latch draw_x and draw_color.
  - Drive a read at draw_x. Go to DRAW_RD.
- IDLE, no request: ram_ce=0.
- DISP_RD:
  - Register ram_dout into pix_color and pulse pix_valid on the next cycle.
  - Clear-on-read (see Configuration): write 0 to the same address.
  - Go to IDLE.
- DRAW_RD:
  - If ram_dout[1:0]==2'b00, write the latched color to the latched address.
  - Otherwise ram_ce=0 and the existing pixel is kept.
  - A new draw_color with [1:0]==00 still writes; the spec does not special-case it. The sprite engine must not send transparent pixels.
  - Go to IDLE.
- draw_ready = (state==IDLE) && !pix_strobe && !pend && !reset. It is combinational.
- Pending latch (one deep):
  - pix_strobe while the FSM is not in IDLE sets pend and stores pix_x.
  - pix_strobe while pend is already set overwrites the stored address and sets pix_overrun.
- Simultaneous pix_strobe and draw_valid in IDLE: the display request wins. draw_ready stays low and the draw pixel is held by the sender.
- pix_overrun clears only on reset.
- Reset (any cycle, including mid-operation):
  - State goes to IDLE. pend=0, pix_valid=0, pix_color=0, pix_overrun=0.
  - In the reset cycle: ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
  - An in-flight draw is dropped.

## Timing
- Display: pix_strobe in IDLE at cycle T → read edge at end of T.
  - Clear write occurs in T+1.
  - pix_valid high in T+2.
  - Back in IDLE in T+2.
- Draw: handshake at T → read at T, conditional write at T+1, draw_ready may be high again at T+2.
- Display throughput: 1 request per 2 clk. pix_strobe spaced ≥3 clk never overruns, even behind a draw.
- RAM controls are combinational from state and latched inputs. pix_color and pix_valid are registered.

## Configuration
- OBJ_LINEBUF_CLEAR_EN defined:
  - DISP_RD writes 0 back to the read address (ram_wre=1, ram_din=0).
  - The buffer self-clears as the line is displayed.
- OBJ_LINEBUF_CLEAR_EN undefined:
  - DISP_RD performs no write (ram_ce=0 in DISP_RD).
  - Buffer contents persist, for debug freeze-frame.
  - Display timing is unchanged.

## Test plan
- Clear-on-read (OBJ_LINEBUF_CLEAR_EN defined):
  - Preload addr 0x10=0x2D.
  - pix_strobe with pix_x=0x10 → pix_valid 2 cycles later with pix_color=0x2D.
  - Second strobe at 0x10 → pix_color=0x00.
  - Without the macro → 0x2D both times.
- Draw into empty location: draw 0x40←0x1B → location 0x40 reads back 0x1B.
- Priority blocking:
  - Draw 0x40←0x1B, then draw 0x40←0x26 → reads back 0x1B; no write cycle in the second DRAW_RD.
  - Location holding 0x3C (code 00) is overwritten by 0x26.
- Simultaneous requests: pix_strobe and draw_valid in the same IDLE cycle → draw_ready=0, display read issued first, draw accepted exactly 2 cycles later.
- Overrun: three pix_strobes on consecutive cycles (x=1,2,3) → addr 1 served, addr 3 served, addr 2 lost, pix_overrun=1 and sticky until reset.
- Reset mid-draw: assert reset in DRAW_RD → no RAM write that cycle, all outputs 0, draw_ready high the cycle after reset deasserts.

Source files
------------

// File: rtl/dkjr_obj_linebuf_ctrl.sv
// Object line-buffer controller: display reads take priority over sprite draws on one RAM port.
// Define OBJ_LINEBUF_CLEAR_EN to clear each location as it is read for display.
module dkjr_obj_linebuf_ctrl #(
  parameter int AW = 8,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_strobe,
  input  logic [AW-1:0] pix_x,
  output logic [DW-1:0] pix_color,
  output logic          pix_valid,
  output logic          pix_overrun,
  input  logic          draw_valid,
  output logic          draw_ready,
  input  logic [AW-1:0] draw_x,
  input  logic [DW-1:0] draw_color,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, DISP_RD, DRAW_RD} state_t;

  state_t        state;
  logic          pend;
  logic [AW-1:0] pend_x;
  logic [AW-1:0] disp_x;
  logic [AW-1:0] draw_x_q;
  logic [DW-1:0] draw_color_q;
  logic          disp_go;
  logic [AW-1:0] disp_addr;

  function automatic logic is_transparent(input logic [DW-1:0] px);
    return px[1:0] == 2'b00;
  endfunction

  // A live strobe beats the stored one: when both exist, the stored address is the lost one.
  assign disp_go    = pix_strobe || pend;
  assign disp_addr  = pix_strobe ? pix_x : pend_x;
  assign draw_ready = (state == IDLE) && !pix_strobe && !pend && !reset;
  assign ram_oce    = 1'b1;
  assign ram_reset  = reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= 1'b0;
      pix_valid   <= 1'b0;
      pix_color   <= '0;
      pix_overrun <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (pix_strobe && pend)
        pix_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (disp_go) begin
            disp_x <= disp_addr;
            pend   <= 1'b0;
            state  <= DISP_RD;
          end else if (draw_valid) begin
            draw_x_q     <= draw_x;
            draw_color_q <= draw_color;
            state        <= DRAW_RD;
          end
        end
        DISP_RD: begin
          pix_color <= ram_dout;
          pix_valid <= 1'b1;
          state     <= IDLE;
        end
        DRAW_RD: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (state != IDLE && pix_strobe) begin
        pend   <= 1'b1;
        pend_x <= pix_x;
      end
    end
  end

  // RAM port is decoded from the current state so a read is issued in the same cycle as the request.
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (disp_go) begin
            ram_ce = 1'b1;
            ram_ad = disp_addr;
          end else if (draw_valid) begin
            ram_ce = 1'b1;
            ram_ad = draw_x;
          end
        end
        DISP_RD: begin
`ifdef OBJ_LINEBUF_CLEAR_EN
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = disp_x;
          ram_din = '0;
`else
          ram_ce  = 1'b0;
`endif
        end
        DRAW_RD: begin
          if (is_transparent(ram_dout)) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = draw_x_q;
            ram_din = draw_color_q;
          end
        end
        default: ram_ce = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dkjr_obj_linebuf_ctrl.sv
// Bench for dkjr_obj_linebuf_ctrl: behavioural 256x6 RAM plus a pixel-level reference buffer.
module tb_dkjr_obj_linebuf_ctrl;

`ifdef OBJ_LINEBUF_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_strobe;
  logic [7:0] pix_x;
  logic [5:0] pix_color;
  logic       pix_valid;
  logic       pix_overrun;
  logic       draw_valid;
  logic       draw_ready;
  logic [7:0] draw_x;
  logic [5:0] draw_color;
  logic       ram_ce, ram_oce, ram_reset, ram_wre;
  logic [7:0] ram_ad;
  logic [5:0] ram_din;
  logic [5:0] ram_dout;

  int checks = 0;
  int passes = 0;

  dkjr_obj_linebuf_ctrl #(.AW(8), .DW(6)) dut (
    .clk(clk), .reset(reset),
    .pix_strobe(pix_strobe), .pix_x(pix_x), .pix_color(pix_color),
    .pix_valid(pix_valid), .pix_overrun(pix_overrun),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_color(draw_color),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, bypass mode: dout shows the read data (or written data) after the edge.
  logic [5:0] mem [256];
  logic [5:0] dout_q;
  logic       pre_we, clr_all;
  logic [7:0] pre_a;
  logic [5:0] pre_d;

  always @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < 256; i++) mem[i] <= 6'h00;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (ram_ce && ram_wre) begin
      mem[ram_ad] <= ram_din;
    end
    if (ram_reset) dout_q <= 6'h00;
    else if (ram_ce) dout_q <= ram_wre ? ram_din : mem[ram_ad];
  end
  assign ram_dout = dout_q;

  // Reference: what each location should hold according to the pixel rules.
  logic [5:0] model_buf [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [5:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_we = 1'b0;
    model_buf[a] = d;
  endtask

  task automatic disp(input logic [7:0] x);
    logic [5:0] exp;
    exp = model_buf[x];
    pix_strobe = 1'b1; pix_x = x;
    #1;
    check("disp_rd_ad", {24'h0, ram_ad}, {24'h0, x});
    check("disp_rd_wre", {31'h0, ram_wre}, 32'h0);
    tick();
    pix_strobe = 1'b0;
    check("disp_clr_wre", {31'h0, ram_wre}, {31'h0, CLR});
    if (CLR) model_buf[x] = 6'h00;
    tick();
    check("disp_valid", {31'h0, pix_valid}, 32'h1);
    check("disp_color", {26'h0, pix_color}, {26'h0, exp});
  endtask

  task automatic draw(input logic [7:0] x, input logic [5:0] c);
    logic wr;
    wr = (model_buf[x][1:0] == 2'b00);
    draw_valid = 1'b1; draw_x = x; draw_color = c;
    #1;
    check("draw_ready", {31'h0, draw_ready}, 32'h1);
    tick();
    draw_valid = 1'b0;
    check("draw_wre", {31'h0, ram_wre}, {31'h0, wr});
    if (wr) model_buf[x] = c;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] e1, e3, e60, c;
    logic [7:0] a;
    logic       wr;
    int         mism;
    for (int i = 0; i < 256; i++) model_buf[i] = 6'h00;
    reset = 1'b1; clr_all = 1'b1; pre_we = 1'b0; pre_a = 8'h00; pre_d = 6'h00;
    pix_strobe = 1'b0; pix_x = 8'h00; draw_valid = 1'b0; draw_x = 8'h00; draw_color = 6'h00;
    tick(); tick();
    clr_all = 1'b0;
    check("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
    check("rst_ram_reset", {31'h0, ram_reset}, 32'h1);
    check("rst_draw_ready", {31'h0, draw_ready}, 32'h0);
    check("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    check("rst_pix_color", {26'h0, pix_color}, 32'h0);
    check("rst_overrun", {31'h0, pix_overrun}, 32'h0);
    check("ram_oce", {31'h0, ram_oce}, 32'h1);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, draw_ready}, 32'h1);
    check("idle_ram_ce", {31'h0, ram_ce}, 32'h0);
    tick();

    // Clear-on-read
    preload(8'h10, 6'h2D);
    disp(8'h10);
    disp(8'h10);

    // Draw into empty location, then priority blocking
    draw(8'h40, 6'h1B);
    disp(8'h40);
    draw(8'h41, 6'h1B);
    draw(8'h41, 6'h26);
    disp(8'h41);
    preload(8'h50, 6'h3C);
    draw(8'h50, 6'h26);
    disp(8'h50);

    // Simultaneous display and draw
    preload(8'h60, 6'h15);
    e60 = model_buf[8'h60];
    pix_strobe = 1'b1; pix_x = 8'h60;
    draw_valid = 1'b1; draw_x = 8'h61; draw_color = 6'h1A;
    #1;
    check("sim_ready_t0", {31'h0, draw_ready}, 32'h0);
    check("sim_ad_t0", {24'h0, ram_ad}, 32'h60);
    tick();
    pix_strobe = 1'b0;
    if (CLR) model_buf[8'h60] = 6'h00;
    check("sim_ready_t1", {31'h0, draw_ready}, 32'h0);
    tick();
    check("sim_valid_t2", {31'h0, pix_valid}, 32'h1);
    check("sim_color_t2", {26'h0, pix_color}, {26'h0, e60});
    check("sim_ready_t2", {31'h0, draw_ready}, 32'h1);
    check("sim_draw_ad", {24'h0, ram_ad}, 32'h61);
    wr = (model_buf[8'h61][1:0] == 2'b00);
    tick();
    draw_valid = 1'b0;
    check("sim_draw_wre", {31'h0, ram_wre}, {31'h0, wr});
    if (wr) model_buf[8'h61] = 6'h1A;
    tick();
    disp(8'h61);

    // Overrun: three back-to-back strobes, the middle one is lost
    preload(8'h01, 6'h05);
    preload(8'h02, 6'h09);
    preload(8'h03, 6'h0E);
    e1 = model_buf[1]; e3 = model_buf[3];
    pix_strobe = 1'b1; pix_x = 8'h01;
    tick();
    pix_x = 8'h02;
    tick();
    pix_x = 8'h03;
    check("ovr_valid1", {31'h0, pix_valid}, 32'h1);
    check("ovr_color1", {26'h0, pix_color}, {26'h0, e1});
    tick();
    pix_strobe = 1'b0;
    check("ovr_flag", {31'h0, pix_overrun}, 32'h1);
    tick();
    check("ovr_valid3", {31'h0, pix_valid}, 32'h1);
    check("ovr_color3", {26'h0, pix_color}, {26'h0, e3});
    if (CLR) begin model_buf[1] = 6'h00; model_buf[3] = 6'h00; end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovr_no_extra", {31'h0, pix_valid}, 32'h0);
    end
    disp(8'h02);

    // Randomized mix of draws, displays and direct loads on a small address window
    for (int n = 0; n < 60; n++) begin
      a = 8'h80 + 8'($urandom_range(0, 7));
      c[5:2] = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1: begin
          c[1:0] = 2'($urandom_range(1, 3));
          draw(a, c);
        end
        2: disp(a);
        default: begin
          c[1:0] = 2'b00;
          preload(a, c);
        end
      endcase
    end
    check("ovr_sticky", {31'h0, pix_overrun}, 32'h1);

    // Reset in the middle of a draw
    preload(8'h71, 6'h33);
    disp(8'h71);
    draw_valid = 1'b1; draw_x = 8'h70; draw_color = 6'h2B;
    tick();
    draw_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rmid_wre", {31'h0, ram_wre}, 32'h0);
    check("rmid_ce", {31'h0, ram_ce}, 32'h0);
    check("rmid_ad", {24'h0, ram_ad}, 32'h0);
    check("rmid_din", {26'h0, ram_din}, 32'h0);
    check("rmid_ready", {31'h0, draw_ready}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rpost_ready", {31'h0, draw_ready}, 32'h1);
    check("rpost_color", {26'h0, pix_color}, 32'h0);
    check("rpost_valid", {31'h0, pix_valid}, 32'h0);
    check("rpost_overrun", {31'h0, pix_overrun}, 32'h0);
    tick();
    disp(8'h70);

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== model_buf[i]) mism++;
    check("mem_final", mism, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
